ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, 10000: clk cycles the PS/2 clock is held low before a request-to-send (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYC, 2000000: maximum clk cycles from clock release to acknowledge (20 ms at 100 MHz).
REQ-003 clk  in  1  system clock, 100 MHz.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 tx_valid  in  1  command byte offered.
REQ-006 tx_data  in  8  command byte, e.g. 0xED (set LEDs).
REQ-007 tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid and tx_ready are both high.
REQ-008 ps2_clk_i  in  1  raw PS2_CLK pad level.
REQ-009 ps2_data_i  in  1  raw PS2_DATA pad level.
REQ-010 ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (open drain).
REQ-011 ps2_data_oe  out  1  1 = drive PS2_DATA low; 0 = release.
REQ-012 busy  out  1  high in every state except IDLE; the receiving keyboard decoder ignores the bus while busy.
REQ-013 done  out  1  one-cycle pulse when a transfer is acknowledged.
REQ-014 err  out  1  one-cycle pulse when a transfer fails.
REQ-015 err_code  out  2  00 none, 01 timeout, 10 no-ack; held until the next accept.

Function
REQ-016 ps2_clk_i and ps2_data_i shall pass through 2-flop synchronisers; a device clock edge is a falling edge of the synchronised clock, detected with one further register stage.
REQ-017 States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE, ERR.
REQ-018 IDLE: both oe = 0. On accept: latch tx_data, compute odd parity (~^tx_data), clear err_code, go to INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYC cycles; ps2_data_oe = 1 in the final cycle. Then go to RTS.
REQ-020 RTS: ps2_clk_oe = 0, ps2_data_oe = 1 (start bit 0). Clear the edge counter and start the timeout counter. Go to SHIFT.
REQ-021 SHIFT: on device falling edges n = 1..8, ps2_data_oe = ~data[n-1] (LSB first). On edge 9, ps2_data_oe = ~parity. On edge 10, ps2_data_oe = 0 (stop bit 1); go to ACK.
REQ-022 ACK: on the next falling edge, synchronised data = 0 means acknowledged and the block goes to WAIT_IDLE. Data = 1 means ERR with err_code 10.
REQ-023 WAIT_IDLE: wait until synchronised clock and data are both high, then go to DONE.
REQ-024 DONE: pulse done, go to IDLE. ERR: pulse err, go to IDLE. Both oe = 0 in DONE and ERR.
REQ-025 Timeout: if the counter reaches TIMEOUT_CYC in RTS, SHIFT, ACK or WAIT_IDLE, go to ERR with err_code 01 and release both lines the same cycle; timeout takes priority over a coincident edge.
REQ-026 tx_valid while busy shall be ignored; there is no queueing.
REQ-027 Edge counter is 4 bits; timeout counter is ceil(log2(TIMEOUT_CYC+1)) bits and saturates, never wraps.
REQ-028 All outputs shall be registered; the oe outputs never glitch.

Reset
REQ-029 rst shall force state IDLE, and force ps2_clk_oe, ps2_data_oe, busy, done, err = 0, tx_ready = 1, err_code = 00, and all counters = 0, on the next clk edge.
REQ-030 rst asserted mid-transfer shall abort the transfer silently (no done/err pulse) and release both lines.

Structure
REQ-031 Package ps2_pkg holds the state enum, err_code constants and the command constants SET_LED = 8'hED and ECHO = 8'hEE.
REQ-032 Sub-module ps2_sync_edge provides the synchroniser and falling-edge detector; it is shared with the keyboard decoder.

Verification
REQ-033 Send 0xED through a device model → start bit 0, line data 1,0,1,1,0,1,1,1, parity 1, stop 1; ack low → done after WAIT_IDLE, err_code 00.
REQ-034 Send 0x01 → parity bit 0; send 0xFF → parity bit 1; both done.
REQ-035 Model never clocks after RTS → err at TIMEOUT_CYC cycles, err_code 01, both oe = 0.
REQ-036 Model holds data high on the 11th edge → err, err_code 10.
REQ-037 rst after the 5th edge → both oe = 0 next cycle, tx_ready = 1, no done/err pulse; a new 0xEE then completes.
REQ-038 tx_valid pulsed during SHIFT with 0x55 → ignored; the original byte is transmitted unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and the
// keyboard decoder.
//   ps2_state_t    host transmitter FSM states
//   ERR_*          err_code values reported by ps2_host_tx
//   SET_LED, ECHO  common keyboard command bytes
//   odd_parity()   PS/2 parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] SET_LED = 8'hED;
    localparam logic [7:0] ECHO    = 8'hEE;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: brings the raw PS/2 pad levels into the clk domain and
// flags falling edges of the device clock.
//   clk, rst    system clock, synchronous active-high reset
//   ps2_clk_i   raw PS2_CLK pad level
//   ps2_data_i  raw PS2_DATA pad level
//   clk_s       synchronised PS2_CLK (2 flops)
//   data_s      synchronised PS2_DATA (2 flops)
//   clk_fall    high for one cycle after clk_s goes 1 -> 0
module ps2_sync_edge
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic clk_m;
    logic data_m;
    logic clk_d;

    // An idle PS/2 bus floats high, so every stage resets to 1; this keeps a
    // reset from manufacturing a phantom falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_m  <= 1'b1;
            clk_s  <= 1'b1;
            clk_d  <= 1'b1;
            data_m <= 1'b1;
            data_s <= 1'b1;
        end else begin
            clk_m  <= ps2_clk_i;
            clk_s  <= clk_m;
            clk_d  <= clk_s;
            data_m <= ps2_data_i;
            data_s <= data_m;
        end
    end

    assign clk_fall = clk_d & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device
// (inhibit, request-to-send, 11-bit frame clocked by the device, ack check).
//   INHIBIT_CYC   clk cycles PS2_CLK is held low before request-to-send
//   TIMEOUT_CYC   clk cycles allowed from clock release to the end of the ack
//   clk, rst      system clock, synchronous active-high reset
//   tx_valid      command byte offered
//   tx_data       command byte
//   tx_ready      high only in IDLE
//   ps2_clk_i     raw PS2_CLK pad level
//   ps2_data_i    raw PS2_DATA pad level
//   ps2_clk_oe    1 pulls PS2_CLK low, 0 releases it
//   ps2_data_oe   1 pulls PS2_DATA low, 0 releases it
//   busy          high whenever a transfer is in progress
//   done          one-cycle pulse: transfer acknowledged
//   err           one-cycle pulse: transfer failed
//   err_code      00 none, 01 timeout, 10 no-ack; held until the next accept
//   state_dbg     current FSM state
//
// Handshake: a byte is taken on a rising clk edge where tx_valid and
// tx_ready are both high. tx_ready is high only while idle; a tx_valid that
// arrives while busy is dropped, not queued, and the producer has to offer
// the byte again once tx_ready returns.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 10000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output ps2_state_t state_dbg
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);

    logic clk_s;
    logic data_s;
    logic clk_fall;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fall   (clk_fall)
    );

    ps2_state_t       state, state_n;
    logic [7:0]       data_q, data_n;
    logic             parity_q, parity_n;
    logic [INH_W-1:0] inh_cnt, inh_cnt_n;
    logic [3:0]       edge_cnt, edge_cnt_n;
    logic [TO_W-1:0]  to_cnt, to_cnt_n;
    logic [1:0]       err_code_n;
    logic             clk_oe_n, data_oe_n;
    logic             done_n, err_n, ready_n;
    logic             timed;

    // Every output is computed from the next state and registered together
    // with it, so the pad enables only ever change on a clock edge.
    always_comb begin
        state_n    = state;
        data_n     = data_q;
        parity_n   = parity_q;
        inh_cnt_n  = inh_cnt;
        edge_cnt_n = edge_cnt;
        to_cnt_n   = to_cnt;
        err_code_n = err_code;
        clk_oe_n   = 1'b0;
        data_oe_n  = ps2_data_oe;

        timed = (state == ST_RTS) || (state == ST_SHIFT) ||
                (state == ST_ACK) || (state == ST_WAIT_IDLE);

        // Saturating: the counter parks at TO_MAX rather than wrapping.
        if (timed && (to_cnt != TO_MAX)) begin
            to_cnt_n = to_cnt + TO_W'(1);
        end

        case (state)
            ST_IDLE: begin
                data_oe_n = 1'b0;
                if (tx_valid && tx_ready) begin
                    data_n     = tx_data;
                    parity_n   = odd_parity(tx_data);
                    err_code_n = ERR_NONE;
                    inh_cnt_n  = '0;
                    to_cnt_n   = '0;
                    clk_oe_n   = 1'b1;
                    data_oe_n  = (INH_LAST == '0);
                    state_n    = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    // Release the clock while data stays low: the start bit
                    // doubles as the request-to-send.
                    data_oe_n  = 1'b1;
                    edge_cnt_n = '0;
                    to_cnt_n   = '0;
                    state_n    = ST_RTS;
                end else begin
                    inh_cnt_n = inh_cnt + INH_W'(1);
                    clk_oe_n  = 1'b1;
                    data_oe_n = (inh_cnt_n == INH_LAST);
                end
            end

            ST_RTS: begin
                data_oe_n = 1'b1;
                state_n   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (clk_fall) begin
                    // Falling edge number edge_cnt+1 selects the next bit.
                    edge_cnt_n = edge_cnt + 4'd1;
                    if (edge_cnt < 4'd8) begin
                        data_oe_n = ~data_q[edge_cnt[2:0]];
                    end else if (edge_cnt == 4'd8) begin
                        data_oe_n = ~parity_q;
                    end else begin
                        data_oe_n = 1'b0;
                        state_n   = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                data_oe_n = 1'b0;
                if (clk_fall) begin
                    if (!data_s) begin
                        state_n = ST_WAIT_IDLE;
                    end else begin
                        err_code_n = ERR_NOACK;
                        state_n    = ST_ERR;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                data_oe_n = 1'b0;
                if (clk_s && data_s) begin
                    state_n = ST_DONE;
                end
            end

            ST_DONE, ST_ERR: begin
                data_oe_n = 1'b0;
                state_n   = ST_IDLE;
            end

            default: begin
                data_oe_n = 1'b0;
                state_n   = ST_IDLE;
            end
        endcase

        // Timeout wins over anything decided above, including an edge that
        // lands in the same cycle.
        if (timed && (to_cnt == TO_MAX)) begin
            clk_oe_n   = 1'b0;
            data_oe_n  = 1'b0;
            edge_cnt_n = edge_cnt;
            err_code_n = ERR_TIMEOUT;
            state_n    = ST_ERR;
        end

        done_n  = (state_n == ST_DONE);
        err_n   = (state_n == ST_ERR);
        ready_n = (state_n == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            data_q      <= '0;
            parity_q    <= 1'b0;
            inh_cnt     <= '0;
            edge_cnt    <= '0;
            to_cnt      <= '0;
            err_code    <= ERR_NONE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            data_q      <= data_n;
            parity_q    <= parity_n;
            inh_cnt     <= inh_cnt_n;
            edge_cnt    <= edge_cnt_n;
            to_cnt      <= to_cnt_n;
            err_code    <= err_code_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            done        <= done_n;
            err         <= err_n;
            tx_ready    <= ready_n;
            busy        <= ~ready_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a simple PS/2 device model on
// open-drain pads and checks frames, handshakes, errors and reset abort.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TO   = 400;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       clk_oe;
    logic       data_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    ps2_state_t state_dbg;

    logic dev_clk_low;
    logic dev_data_low;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // ---------------- clock / pads ----------------
    always #5 clk = ~clk;

    // Open-drain bus with pull-ups: the line is low if anyone pulls it.
    assign ps2_clk_i  = ~(clk_oe | dev_clk_low);
    assign ps2_data_i = ~(data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (clk_oe),
        .ps2_data_oe (data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .state_dbg   (state_dbg)
    );

    // Pulse counters: a pulse wider than one cycle shows up as extra counts.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    // ---------------- reference model ----------------
    // Line frame as seen on PS2_DATA, bit 0 = start bit first on the wire.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_tx(input logic [7:0] d);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Measures the inhibit phase and returns at the first sample after it.
    task automatic wait_rts(output bit ok);
        int   n;
        int   inh;
        int   dc;
        logic last_d;
        n = 0; inh = 0; dc = 0; last_d = 1'b0;
        while (clk_oe !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (clk_oe === 1'b1 && n < INH + 100) begin
            inh++;
            last_d = data_oe;
            if (data_oe === 1'b1) dc++;
            @(negedge clk);
            n++;
        end
        check("inhibit_len", 32'(inh), 32'(INH));
        check("inhibit_data_cycles", 32'(dc), 32'd1);
        check("inhibit_data_last", 32'(last_d), 32'd1);
        ok = (inh > 0) && (clk_oe === 1'b0) && (data_oe === 1'b1);
        check("rts_seen", 32'(ok), 32'd1);
    endtask

    task automatic dev_pulse(output logic b);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        b = ps2_data_i;
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // Device side of one frame: start bit, 10 clocked bits, then the ack clock.
    task automatic run_frame(input bit ack_low, input int inject_edge, input int abort_edge,
                             output logic [10:0] got, output bit ok);
        logic b;
        got = '0;
        wait_rts(ok);
        if (!ok) return;
        repeat (HALF) @(negedge clk);
        got[0] = ps2_data_i;
        for (int e = 1; e <= 10; e++) begin
            dev_pulse(b);
            got[e] = b;
            if (e == inject_edge) begin
                check("ready_in_shift", 32'(tx_ready), 32'd0);
                check("busy_in_shift", 32'(busy), 32'd1);
                tx_valid = 1'b1;
                tx_data  = 8'h55;
                @(negedge clk);
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
            if (e == abort_edge) return;
        end
        dev_data_low = ack_low;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_result(input int d0, input int e0, output int dd, output int de);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        dd = done_cnt - d0;
        de = err_cnt - e0;
    endtask

    task automatic send_ok(input logic [7:0] d, input int inject_edge, input string tag,
                           output logic [10:0] got);
        bit ok;
        int d0, e0, dd, de;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        run_frame(1'b1, inject_edge, 0, got, ok);
        check({tag, "_frame"}, 32'(got), 32'(frame_of(d)));
        wait_result(d0, e0, dd, de);
        check({tag, "_done"}, 32'(dd), 32'd1);
        check({tag, "_no_err"}, 32'(de), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_idle"}, 32'({busy, tx_ready, clk_oe, data_oe}), 32'b0100);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] got;
        logic [7:0]  d;
        bit          ok;
        int          d0, e0, dd, de, cnt;

        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'({clk_oe, data_oe}), 32'd0);
        check("rst_pulses", 32'({done, err}), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Set-LED command: exact wire pattern 0,1,0,1,1,0,1,1,1,1,1.
        send_ok(8'hED, 0, "set_led", got);
        check("set_led_wire", 32'(got), 32'h7DA);

        send_ok(8'h01, 0, "byte01", got);
        check("byte01_parity", 32'(got[9]), 32'd0);
        send_ok(8'hFF, 0, "byteff", got);
        check("byteff_parity", 32'(got[9]), 32'd1);

        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            send_ok(d, 0, "random", got);
        end

        // tx_valid during SHIFT must not disturb the byte in flight.
        d = 8'($urandom_range(0, 255));
        if (d == 8'h55) d = 8'hAA;
        send_ok(d, 3, "ignore_valid", got);
        repeat (40) @(negedge clk);
        check("ignore_valid_no_restart", 32'({busy, clk_oe}), 32'd0);

        // Device leaves data high on the ack clock.
        d = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        run_frame(1'b0, 0, 0, got, ok);
        check("noack_frame", 32'(got), 32'(frame_of(d)));
        wait_result(d0, e0, dd, de);
        check("noack_err", 32'(de), 32'd1);
        check("noack_no_done", 32'(dd), 32'd0);
        check("noack_code", 32'(err_code), 32'b10);
        check("noack_oe", 32'({clk_oe, data_oe}), 32'd0);

        // Device never clocks: timeout counted from clock release.
        start_tx(8'($urandom_range(0, 255)));
        wait_rts(ok);
        cnt = 0;
        while (err !== 1'b1 && cnt < TO + 50) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_window", 32'((cnt >= TO) && (cnt <= TO + 2)), 32'd1);
        check("timeout_oe", 32'({clk_oe, data_oe}), 32'd0);
        check("timeout_code", 32'(err_code), 32'b01);
        repeat (3) @(negedge clk);

        // Reset after the 5th device edge aborts silently.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h3C);
        run_frame(1'b1, 0, 5, got, ok);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_oe", 32'({clk_oe, data_oe}), 32'd0);
        check("abort_ready", 32'({tx_ready, busy}), 32'b10);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_silent", 32'({done_cnt - d0, err_cnt - e0}), 32'd0);

        send_ok(8'hEE, 0, "echo_after_rst", got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
